ie_sequencer: RTL

Parametrised interrupt/exception entry-and-return sequencer for the fetch stage. It arbitrates among `NUM_SRC` prioritised interrupt/exception requests and computes the IDT entry address. It captures the architectural state reported by writeback, then injects a fixed micro-sequence of 128-bit instruction packets into fetch2 in place of IBUFF output. It performs the matching return sequence on IRETD and optionally latches requests that arrive while a handler is running.

---
 rtl/ie_sequencer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ie_sequencer.sv
// rtl/ie_sequencer.sv - interrupt/exception entry and IRETD return packet sequencer for fetch2.
// Optional pending-request latch is enabled by defining IE_PENDING_LATCH_EN.
module ie_sequencer #(
  parameter int NUM_SRC  = 3,
  parameter int VEC_BASE = 13,
  parameter int PKT_W    = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] ie_req,
  input  logic [31:0]        idtr_base,
  input  logic [31:0]        eip_wb,
  input  logic [17:0]        eflags_wb,
  input  logic [15:0]        cs_wb,
  input  logic               is_iretd,
  input  logic               final_instr_wb,
  input  logic               pkt_ready,
  output logic [PKT_W-1:0]   pkt_out,
  output logic               pkt_valid,
  output logic               pkt_sel,
  output logic               flush_pipe,
  output logic               ld_eip,
  output logic               servicing,
  output logic               switching,
  output logic [7:0]         vec_out
);

  // S_XFLUSH is the flush cycle between SERVICE and the first EXIT packet.
  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_ENTRY, S_WAIT_E, S_SERVICE, S_XFLUSH, S_EXIT, S_WAIT_X
  } state_t;

  state_t       state, state_next;
  logic [3:0]   k, k_next;
  logic         arbitrate;
  logic         ld_set;
  logic         accept;

  logic [31:0]  cap_addr, cap_addr4, cap_eflags, cap_cs, cap_eip;
  logic [7:0]   cap_vec;

  logic [NUM_SRC-1:0] arb_src;
  logic [7:0]   win_idx;
  logic [7:0]   win_vec;
  logic [31:0]  win_addr;
  logic [127:0] pkt128;

`ifdef IE_PENDING_LATCH_EN
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] win_mask;

  assign arb_src = (state == S_WAIT_X) ? pend : ie_req;

  always_comb begin
    win_mask = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (arb_src[i]) begin
        win_mask    = '0;
        win_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else if (arbitrate) begin
      pend <= (pend & ~win_mask) | ((state == S_IDLE) ? '0 : ie_req);
    end else if (state != S_IDLE) begin
      pend <= pend | ie_req;
    end
  end
`else
  assign arb_src = ie_req;
`endif

  always_comb begin
    win_idx = 8'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (arb_src[i]) win_idx = 8'(i);
    end
  end

  assign win_vec  = 8'(VEC_BASE) + win_idx;
  assign win_addr = idtr_base + {21'b0, win_vec, 3'b000};
  assign accept   = pkt_valid && pkt_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      k     <= 4'd0;
    end else begin
      state <= state_next;
      k     <= k_next;
    end
  end

  always_comb begin
    state_next = state;
    k_next     = k;
    arbitrate  = 1'b0;
    ld_set     = 1'b0;
    pkt_valid  = 1'b0;
    pkt_sel    = 1'b0;
    servicing  = 1'b0;
    switching  = 1'b0;
    case (state)
      S_IDLE: begin
        if (|ie_req) begin
          state_next = S_FLUSH;
          arbitrate  = 1'b1;
        end
      end
      S_FLUSH: begin
        pkt_sel    = 1'b1;
        switching  = 1'b1;
        state_next = S_ENTRY;
        k_next     = 4'd0;
      end
      S_ENTRY: begin
        pkt_valid = 1'b1;
        pkt_sel   = 1'b1;
        servicing = 1'b1;
        switching = 1'b1;
        if (accept) begin
          if (k == 4'd8) begin
            state_next = S_WAIT_E;
            k_next     = 4'd0;
          end else begin
            k_next = k + 4'd1;
          end
        end
      end
      S_WAIT_E: begin
        pkt_sel   = 1'b1;
        servicing = 1'b1;
        switching = 1'b1;
        if (final_instr_wb) begin
          state_next = S_SERVICE;
          ld_set     = 1'b1;
        end
      end
      S_SERVICE: begin
        servicing = 1'b1;
        if (is_iretd) state_next = S_XFLUSH;
      end
      S_XFLUSH: begin
        pkt_sel    = 1'b1;
        servicing  = 1'b1;
        switching  = 1'b1;
        state_next = S_EXIT;
        k_next     = 4'd0;
      end
      S_EXIT: begin
        pkt_valid = 1'b1;
        pkt_sel   = 1'b1;
        servicing = 1'b1;
        switching = 1'b1;
        if (accept) begin
          if (k == 4'd1) begin
            state_next = S_WAIT_X;
            k_next     = 4'd0;
          end else begin
            k_next = k + 4'd1;
          end
        end
      end
      S_WAIT_X: begin
        pkt_sel   = 1'b1;
        servicing = 1'b1;
        switching = 1'b1;
        if (final_instr_wb) begin
          ld_set     = 1'b1;
          state_next = S_IDLE;
`ifdef IE_PENDING_LATCH_EN
          if (|pend) begin
            state_next = S_FLUSH;
            arbitrate  = 1'b1;
          end
`endif
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pulses are registered so they line up with the FLUSH/XFLUSH cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_pipe <= 1'b0;
      ld_eip     <= 1'b0;
    end else begin
      flush_pipe <= (state_next == S_FLUSH) || (state_next == S_XFLUSH);
      ld_eip     <= (state_next == S_FLUSH) || ld_set;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_addr   <= 32'd0;
      cap_addr4  <= 32'd0;
      cap_eflags <= 32'd0;
      cap_cs     <= 32'd0;
      cap_eip    <= 32'd0;
      cap_vec    <= 8'd0;
    end else if (arbitrate) begin
      cap_addr   <= win_addr;
      cap_addr4  <= win_addr + 32'd4;
      cap_eflags <= {14'b0, eflags_wb};
      cap_cs     <= {16'b0, cs_wb};
      cap_eip    <= eip_wb;
      cap_vec    <= win_vec;
    end
  end

  assign vec_out = (state == S_IDLE) ? 8'd0 : cap_vec;

  function automatic logic [31:0] le32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  always_comb begin
    pkt128 = '0;
    if (state == S_ENTRY) begin
      case (k)
        4'd0:    pkt128 = {8'h68, le32(cap_eflags), 88'h0};
        4'd1:    pkt128 = {8'h68, le32(cap_cs), 88'h0};
        4'd2:    pkt128 = {8'h68, le32(cap_eip), 88'h0};
        4'd3:    pkt128 = {16'h8B0D, le32(cap_addr), 80'h0};
        4'd4:    pkt128 = {16'h8B15, le32(cap_addr4), 80'h0};
        4'd5:    pkt128 = {24'h6687D1, 104'h0};
        4'd6:    pkt128 = {24'hC1F904, 104'h0};
        4'd7:    pkt128 = {24'h668EC9, 104'h0};
        4'd8:    pkt128 = {16'hFFE2, 112'h0};
        default: pkt128 = '0;
      endcase
    end else if (state == S_EXIT) begin
      pkt128 = (k == 4'd0) ? {8'hCB, 120'h0} : {8'h59, 120'h0};
    end
  end

  assign pkt_out = PKT_W'(pkt128) << (PKT_W - 128);

endmodule
